bsearch_ctrl: RTL and testbench

Sequential binary-search controller for the sorted register-lookup lab. On a start pulse it searches a synchronous on-chip RAM of 2^ADDR_W ascending unsigned words for a latched target value and reports found / not-found plus the matching address. It sits directly upstream of the two HEX-digit decoders: its nibble and blank outputs connect straight to their 4-bit value and blank inputs.

---
 rtl/bsearch_ctrl.sv | 126 ++++++++++++
 tb/tb_bsearch_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bsearch_ctrl.sv
// rtl/bsearch_ctrl.sv - sequential binary-search controller over a 2-cycle-latency sorted RAM
module bsearch_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] result_addr,
  output logic [3:0]        disp_hi,
  output logic [3:0]        disp_lo,
  output logic              disp_blank
);

  // Bounds carry one extra bit beyond sign+address so that low = 2^ADDR_W
  // (search ran off the top) is a plain positive number and never wraps.
  localparam int PW = ADDR_W + 2;
  localparam logic signed [PW-1:0] ONE       = {{(PW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] HIGH_INIT = {2'b00, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic signed [PW-1:0]     low_q, low_d;
  logic signed [PW-1:0]     high_q, high_d;
  logic        [DATA_W-1:0] tgt_q, tgt_d;
  logic                     found_q, found_d;
  logic        [ADDR_W-1:0] result_addr_q, result_addr_d;

  logic signed [PW-1:0]     mid;
  logic signed [PW-1:0]     mid_inc;
  logic signed [PW-1:0]     mid_dec;
  logic        [7:0]        result_ext;

  // Midpoint floor((low+high)/2) formed without a wider intermediate sum.
  always_comb begin
    mid     = (low_q >>> 1) + (high_q >>> 1)
            + $signed({{(PW-1){1'b0}}, low_q[0] & high_q[0]});
    mid_inc = mid + ONE;
    mid_dec = mid - ONE;
  end

  // State and search registers; reset aborts any search at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      low_q         <= '0;
      high_q        <= '0;
      tgt_q         <= '0;
      found_q       <= 1'b0;
      result_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      low_q         <= low_d;
      high_q        <= high_d;
      tgt_q         <= tgt_d;
      found_q       <= found_d;
      result_addr_q <= result_addr_d;
    end
  end

  // Next-state: launch on start from IDLE/DONE, 3-cycle probe, narrow on compare.
  always_comb begin
    state_d       = state_q;
    low_d         = low_q;
    high_d        = high_q;
    tgt_d         = tgt_q;
    found_d       = found_q;
    result_addr_d = result_addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          low_d         = '0;
          high_d        = HIGH_INIT;
          tgt_d         = target;
          found_d       = 1'b0;
          result_addr_d = '0;
          state_d       = S_ADDR;
        end
      end
      S_ADDR: state_d = S_WAIT;
      S_WAIT: state_d = S_CMP;
      S_CMP: begin
        if (ram_rdata == tgt_q) begin
          found_d       = 1'b1;
          result_addr_d = mid[ADDR_W-1:0];
          state_d       = S_DONE;
        end else if (ram_rdata < tgt_q) begin
          low_d   = mid_inc;
          state_d = (mid_inc > high_q) ? S_DONE : S_ADDR;
        end else begin
          high_d  = mid_dec;
          state_d = (low_q > mid_dec) ? S_DONE : S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status, RAM address and HEX display drive.
  always_comb begin
    result_ext                = '0;
    result_ext[ADDR_W-1:0]    = result_addr_q;
    busy        = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_CMP);
    done        = (state_q == S_DONE);
    found       = found_q;
    result_addr = result_addr_q;
    ram_addr    = mid[ADDR_W-1:0];
    disp_hi     = result_ext[7:4];
    disp_lo     = result_ext[3:0];
    disp_blank  = ~(done & found_q);
  end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// tb/tb_bsearch_ctrl.sv - directed table, control sequences and randomized model check for bsearch_ctrl
module tb_bsearch_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] target;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy, done, found, disp_blank;
  logic [ADDR_W-1:0] result_addr;
  logic [3:0]        disp_hi, disp_lo;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_r;

  int tests = 0;
  int fails = 0;

  bsearch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .found(found), .result_addr(result_addr),
    .disp_hi(disp_hi), .disp_lo(disp_lo), .disp_blank(disp_blank)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous RAM: address captured, then data registered.
  always @(posedge clk) begin
    addr_r    <= ram_addr;
    ram_rdata <= mem[addr_r];
  end

  typedef struct {
    logic [7:0] tgt;
    int         exp_found;
    int         exp_addr;
    int         exp_cycle;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: textbook binary search on integers; each probe costs 3 cycles.
  task automatic model(input int t, output int f, output int a, output int cyc);
    int lo, hi, k, m;
    lo = 0; hi = DEPTH - 1; k = 0; f = 0; a = 0;
    while (lo <= hi && f == 0) begin
      m = (lo + hi) / 2;
      k++;
      if (int'(mem[m]) == t) begin
        f = 1; a = m;
      end else if (int'(mem[m]) < t) lo = m + 1;
      else hi = m - 1;
    end
    cyc = 3 * k + 1;
  endtask

  // Issue start at edge 0 and return the cycle in which done is first seen.
  task automatic launch(input logic [7:0] t, output int cyc);
    @(negedge clk);
    start  = 1'b1;
    target = t;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_search(input string name, input logic [7:0] t,
                            input int ef, input int ea, input int ec);
    int cyc;
    launch(t, cyc);
    check({name, ".done_cycle"}, cyc, ec);
    check({name, ".found"}, int'(found), ef);
    check({name, ".result_addr"}, int'(result_addr), ea);
    check({name, ".disp_hi"}, int'(disp_hi), ea / 16);
    check({name, ".disp_lo"}, int'(disp_lo), ea % 16);
    check({name, ".disp_blank"}, int'(disp_blank), (ef != 0) ? 0 : 1);
    check({name, ".busy"}, int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".busy"}, int'(busy), 0);
    check({name, ".done"}, int'(done), 0);
    check({name, ".found"}, int'(found), 0);
    check({name, ".result_addr"}, int'(result_addr), 0);
    check({name, ".ram_addr"}, int'(ram_addr), 0);
    check({name, ".disp_hi"}, int'(disp_hi), 0);
    check({name, ".disp_lo"}, int'(disp_lo), 0);
    check({name, ".disp_blank"}, int'(disp_blank), 1);
  endtask

  initial begin
    vec_t vecs[5];
    int cyc, ef, ea, ec;
    logic [7:0] t;

    vecs[0] = '{8'd30, 1, 15, 4};
    vecs[1] = '{8'd0,  1, 0,  16};
    vecs[2] = '{8'd62, 1, 31, 19};
    vecs[3] = '{8'd7,  0, 0,  16};
    vecs[4] = '{8'd63, 0, 0,  19};

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(2 * i);
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      run_search($sformatf("vec%0d", i), vecs[i].tgt,
                 vecs[i].exp_found, vecs[i].exp_addr, vecs[i].exp_cycle);

    // Result holds in DONE while start stays low.
    repeat (5) @(posedge clk);
    #1;
    check("hold.done", int'(done), 1);
    check("hold.found", int'(found), 0);

    // Restart from DONE: display blanks in cycle 1, completes in cycle 4.
    run_search("pre_restart", 8'd62, 1, 31, 19);
    @(negedge clk);
    start = 1'b1; target = 8'd30;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart.cleared_addr", int'(result_addr), 0);
    check("restart.blank", int'(disp_blank), 1);
    check("restart.busy", int'(busy), 1);
    cyc = 1;
    while (!done && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    check("restart.done_cycle", cyc, 4);
    check("restart.result_addr", int'(result_addr), 15);

    // Start while busy is ignored, including a changed target.
    @(negedge clk);
    start = 1'b1; target = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cyc == 5) begin
        @(negedge clk);
        start = 1'b1; target = 8'd30;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    check("busy_start.done_cycle", cyc, 16);
    check("busy_start.found", int'(found), 1);
    check("busy_start.result_addr", int'(result_addr), 0);

    // Reset asserted in WAIT acts immediately, no clock edge needed.
    @(negedge clk);
    start = 1'b1; target = 8'd62;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    check("wait_state.busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("after_reset");

    // Randomized ascending RAM contents (duplicates allowed) vs. the model.
    for (int r = 0; r < 8; r++) begin
      mem[0] = 8'($urandom_range(0, 5));
      for (int i = 1; i < DEPTH; i++) mem[i] = mem[i-1] + 8'($urandom_range(0, 7));
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 1) == 1) t = mem[$urandom_range(0, DEPTH - 1)];
        else t = 8'($urandom_range(0, 255));
        model(int'(t), ef, ea, ec);
        run_search($sformatf("rnd%0d_%0d_t%0d", r, j, t), t, ef, ea, ec);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
